// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase codes and default phase durations for the
// highway / country-road intersection sequencer.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [2:0] {
        HWY_GREEN   = 3'd0,
        HWY_YELLOW  = 3'd1,
        ALL_RED_H   = 3'd2,
        CTRY_GREEN  = 3'd3,
        CTRY_YELLOW = 3'd4,
        ALL_RED_C   = 3'd5,
        PED_WALK    = 3'd6
    } phase_t;

    localparam int unsigned DEF_T_MIN_GREEN = 8;
    localparam int unsigned DEF_T_MAX_CTRY  = 10;
    localparam int unsigned DEF_T_YELLOW    = 3;
    localparam int unsigned DEF_T_ALLRED    = 2;
    localparam int unsigned DEF_T_WALK      = 6;
    localparam int unsigned DEF_CW          = 8;

    typedef struct packed {
        logic [1:0] hwy;
        logic [1:0] country;
        logic       walk;
    } lamps_t;

    function automatic lamps_t lamp_decode(input phase_t p);
        lamps_t l;
        l.hwy     = RED;
        l.country = RED;
        l.walk    = 1'b0;
        case (p)
            HWY_GREEN:   l.hwy     = GREEN;
            HWY_YELLOW:  l.hwy     = YELLOW;
            CTRY_GREEN:  l.country = GREEN;
            CTRY_YELLOW: l.country = YELLOW;
            PED_WALK:    l.walk    = 1'b1;
            default:     ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Cycle counter for the current phase: synchronous clear, count enable and
// optional saturation at all-ones.
module phase_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic          saturate,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !(saturate && (count == '1))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Top-level intersection sequencer: highway/country green-yellow-all-red
// cycling with a latched pedestrian request served from the highway side.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int unsigned T_MAX_CTRY  = DEF_T_MAX_CTRY,
    parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
    parameter int unsigned T_ALLRED    = DEF_T_ALLRED,
    parameter int unsigned T_WALK      = DEF_T_WALK,
    parameter int unsigned CW          = DEF_CW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_country,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] country,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [CW-1:0] MIN_LAST  = CW'(T_MIN_GREEN - 1);
    localparam logic [CW-1:0] CTRY_LAST = CW'(T_MAX_CTRY - 1);
    localparam logic [CW-1:0] YEL_LAST  = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] AR_LAST   = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] WALK_LAST = CW'(T_WALK - 1);

    phase_t        state;
    phase_t        nxt;
    logic [CW-1:0] timer;
    logic          ped_pending;
    logic          change;
    logic          enter_walk;
    lamps_t        next_lamps;

    phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (change),
        .enable   (1'b1),
        .saturate (state == HWY_GREEN),
        .count    (timer)
    );

    always_comb begin
        nxt = state;
        case (state)
            HWY_GREEN:   if (timer >= MIN_LAST && (car_country || ped_pending)) nxt = HWY_YELLOW;
            HWY_YELLOW:  if (timer == YEL_LAST) nxt = ALL_RED_H;
            ALL_RED_H:   if (timer == AR_LAST) nxt = ped_pending ? PED_WALK : CTRY_GREEN;
            CTRY_GREEN:  if (!car_country || timer == CTRY_LAST) nxt = CTRY_YELLOW;
            CTRY_YELLOW: if (timer == YEL_LAST) nxt = ALL_RED_C;
            ALL_RED_C:   if (timer == AR_LAST) nxt = HWY_GREEN;
            PED_WALK:    if (timer == WALK_LAST) nxt = ALL_RED_C;
            default:     nxt = HWY_GREEN;
        endcase
    end

    assign change     = (nxt != state);
    assign enter_walk = change && (nxt == PED_WALK);
    assign next_lamps = lamp_decode(nxt);
    assign phase      = state;

    // Lamps are decoded from the next state so the registered outputs track the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HWY_GREEN;
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
            hwy         <= GREEN;
            country     <= RED;
            walk        <= 1'b0;
        end else begin
            state   <= nxt;
            ped_ack <= enter_walk;
            hwy     <= next_lamps.hwy;
            country <= next_lamps.country;
            walk    <= next_lamps.walk;
            if (enter_walk) begin
                ped_pending <= 1'b0;
            end else if (ped_req && state != PED_WALK) begin
                ped_pending <= 1'b1;
            end
        end
    end

endmodule
